// File: rtl/dataflow_fanout_buffer_pkg.sv
// Shared definitions for the fan-out buffer: handshake roles and width helper.
package dataflow_fanout_buffer_pkg;

    // Role this block plays on each side of a req/ack handshake.
    typedef enum logic {
        HS_INITIATOR = 1'b0,
        HS_RESPONDER = 1'b1
    } hs_role_e;

    localparam hs_role_e UPSTREAM_ROLE   = HS_INITIATOR;
    localparam hs_role_e DOWNSTREAM_ROLE = HS_RESPONDER;

    // Ceiling log2, used to size pointers (DEPTH entries) and the level count.
    function automatic int fb_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/dataflow_fanout_port.sv
// One downstream consumer: read pointer plus registered ack pulse and data.
module dataflow_fanout_port
    import dataflow_fanout_buffer_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 4,
    localparam int PTR_W      = fb_clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  avail_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  take_o,
    output logic [PTR_W-1:0]      rd_ptr_o,
    output logic                  ack_o,
    output logic [DATA_WIDTH-1:0] dout_o
);

    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  ack_q, ack_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  take;

    // A read is taken only when the previous ack has already dropped, which
    // caps each consumer at one word every two cycles.
    assign take = req_i & ~ack_q & avail_i;

    // Next-state: pointer advance, ack pulse and data capture on a taken read.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        ack_d    = take;
        dout_d   = dout_q;
        if (take) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            dout_d   = data_i;
        end
    end

    // Consumer state registers; reset clears pointer, ack and data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            ack_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            ack_q    <= ack_d;
            dout_q   <= dout_d;
        end
    end

    assign take_o   = take;
    assign rd_ptr_o = rd_ptr_q;
    assign ack_o    = ack_q;
    assign dout_o   = dout_q;

endmodule

// File: rtl/dataflow_fanout_buffer.sv
// Fan-out buffer: one upstream writer, NUM_OUT independent readers, each word
// kept until every reader has taken it.
//
// Handshakes: upstream, this block raises req_l and holds it until a one-cycle
// ack_l arrives with din valid; ack_l while req_l is low is ignored. Downstream,
// consumer i holds req_r[i] high while it wants data and this block answers
// with a one-cycle registered ack_r[i], dout slice i valid in that cycle.
module dataflow_fanout_buffer
    import dataflow_fanout_buffer_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_OUT    = 2,
    parameter  int DEPTH      = 4,
    localparam int PTR_W      = fb_clog2(DEPTH),
    localparam int LVL_W      = PTR_W + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          req_l,
    input  logic                          ack_l,
    input  logic [DATA_WIDTH-1:0]         din,
    input  logic [NUM_OUT-1:0]            req_r,
    output logic [NUM_OUT-1:0]            ack_r,
    output logic [NUM_OUT*DATA_WIDTH-1:0] dout,
    output logic [LVL_W-1:0]              level
);

    // Storage: one word and one pending-consumer mask per entry.
    logic [DATA_WIDTH-1:0] mem_q  [DEPTH];
    logic [NUM_OUT-1:0]    mask_q [DEPTH];
    logic [NUM_OUT-1:0]    mask_d [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic                  req_l_q, req_l_d;
    logic                  wr_en;
    logic                  wr_free;

    logic [PTR_W-1:0]      rd_ptr  [NUM_OUT];
    logic [DATA_WIDTH-1:0] rd_data [NUM_OUT];
    logic [NUM_OUT-1:0]    avail;
    logic [NUM_OUT-1:0]    take;
    logic [LVL_W-1:0]      level_cnt;

    // A write needs an outstanding request; a stray ack_l is dropped here.
    assign wr_en   = ack_l & req_l_q;
    assign wr_free = (mask_q[wr_ptr_q] == '0);

    // Upstream request control: raise when idle and the write slot is free,
    // drop on the accepted write.
    always_comb begin
        req_l_d  = req_l_q;
        wr_ptr_d = wr_ptr_q;
        if (wr_en) begin
            req_l_d  = 1'b0;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else if (!req_l_q && !ack_l && wr_free) begin
            req_l_d = 1'b1;
        end
    end

    // Mask update: readers clear their own bit, a write fills its entry.
    // The write slot is always free, so it never collides with a read.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            mask_d[e] = mask_q[e];
            for (int i = 0; i < NUM_OUT; i++) begin
                if (take[i] && (rd_ptr[i] == PTR_W'(e))) begin
                    mask_d[e][i] = 1'b0;
                end
            end
            if (wr_en && (wr_ptr_q == PTR_W'(e))) begin
                mask_d[e] = '1;
            end
        end
    end

    // Occupancy: entries whose mask still has any pending consumer.
    always_comb begin
        level_cnt = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (mask_q[e] != '0) begin
                level_cnt = level_cnt + LVL_W'(1);
            end
        end
    end

    // Upstream pointer and request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            req_l_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            req_l_q  <= req_l_d;
        end
    end

    // Entry masks; reset empties every entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                mask_q[e] <= '0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                mask_q[e] <= mask_d[e];
            end
        end
    end

    // Entry data; reset discards buffered words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_OUT; g++) begin : g_port
            assign avail[g]   = mask_q[rd_ptr[g]][g];
            assign rd_data[g] = mem_q[rd_ptr[g]];

            dataflow_fanout_port #(
                .DATA_WIDTH (DATA_WIDTH),
                .DEPTH      (DEPTH)
            ) u_port (
                .clk      (clk),
                .rst      (rst),
                .req_i    (req_r[g]),
                .avail_i  (avail[g]),
                .data_i   (rd_data[g]),
                .take_o   (take[g]),
                .rd_ptr_o (rd_ptr[g]),
                .ack_o    (ack_r[g]),
                .dout_o   (dout[DATA_WIDTH*g +: DATA_WIDTH])
            );
        end
    endgenerate

    assign req_l = req_l_q;
    assign level = level_cnt;

endmodule

// File: tb/tb_dataflow_fanout_buffer.sv
// Bench for dataflow_fanout_buffer: directed phases with a per-consumer
// expected-word queue filled by the upstream responder model.
module tb_dataflow_fanout_buffer;

  localparam int DW = 32;
  localparam int NO = 2;
  localparam int DP = 4;
  localparam int LW = 3;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst;
  logic            req_l;
  logic            ack_l;
  logic [DW-1:0]   din;
  logic [NO-1:0]   req_r;
  logic [NO-1:0]   ack_r;
  logic [NO*DW-1:0] dout;
  logic [LW-1:0]   level;

  always #5 clk = ~clk;

  dataflow_fanout_buffer #(
    .DATA_WIDTH (DW),
    .NUM_OUT    (NO),
    .DEPTH      (DP)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req_l (req_l),
    .ack_l (ack_l),
    .din   (din),
    .req_r (req_r),
    .ack_r (ack_r),
    .dout  (dout),
    .level (level)
  );

  // ---------------- scoreboard state ----------------
  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int got0 = 0;
  int got1 = 0;
  int up_sent = 0;
  int up_limit = 0;
  logic [DW-1:0] next_val = '0;
  logic [1:0] c_en = 2'b00;
  logic [1:0] c_rand = 2'b00;
  int lim0 = 0;
  int lim1 = 0;
  bit inj_pending = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- driver / monitor: one clock per call ----------------
  // negedge: compare delivered words; posedge+1: drive upstream and consumers;
  // returns at posedge+2 so directed checks sample settled outputs.
  task automatic step();
    logic [DW-1:0] e;
    @(negedge clk);
    if (!rst) begin
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      if (ack_r[0]) begin
        check("c0_word_expected", 64'(exp_q0.size() > 0), 64'd1);
        if (exp_q0.size() > 0) begin
          e = exp_q0.pop_front();
          check("c0_data", 64'(dout[DW-1:0]), 64'(e));
        end
        got0++;
      end
      if (ack_r[1]) begin
        check("c1_word_expected", 64'(exp_q1.size() > 0), 64'd1);
        if (exp_q1.size() > 0) begin
          e = exp_q1.pop_front();
          check("c1_data", 64'(dout[2*DW-1:DW]), 64'(e));
        end
        got1++;
      end
    end
    @(posedge clk);
    #1;
    // upstream responder
    if (!rst) begin
      ack_l = 1'b0;
    end else if (inj_pending && !req_l && !ack_l) begin
      ack_l = 1'b1;
      din = 32'd77;
      inj_pending = 1'b0;
    end else if (req_l && !ack_l && (up_sent < up_limit)) begin
      ack_l = 1'b1;
      din = next_val;
      exp_q0.push_back(next_val);
      exp_q1.push_back(next_val);
      next_val = next_val + 1;
      up_sent++;
    end else begin
      ack_l = 1'b0;
    end
    // consumers: hold request until the wanted number of words has arrived
    req_r[0] = rst && c_en[0] && ((got0 + int'(ack_r[0])) < lim0) &&
               (!c_rand[0] || ($urandom_range(0, 1) == 1));
    req_r[1] = rst && c_en[1] && ((got1 + int'(ack_r[1])) < lim1) &&
               (!c_rand[1] || ($urandom_range(0, 1) == 1));
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int g0;
    int g1;
    rst = 1'b0;
    ack_l = 1'b0;
    din = '0;
    req_r = '0;

    // reset state
    #2;
    check("rst_req_l", 64'(req_l), 64'd0);
    check("rst_ack_r", 64'(ack_r), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    step();
    step();
    rst = 1'b1;

    // single word 5, both consumers waiting
    c_en = 2'b11;
    lim0 = 1000000;
    lim1 = 1000000;
    up_limit = up_sent + 1;
    next_val = 32'd5;
    n = 0;
    while (ack_l !== 1'b1 && n < 20) begin step(); n++; end
    check("single_ack_l_timeout", 64'(n < 20), 64'd1);
    check("single_pre_level", 64'(level), 64'd0);
    step();
    check("single_write_level", 64'(level), 64'd1);
    check("single_no_same_edge_ack", 64'(ack_r), 64'd0);
    check("single_req_l_cleared", 64'(req_l), 64'd0);
    step();
    check("single_ack_both", 64'(ack_r), 64'd3);
    check("single_dout0", 64'(dout[DW-1:0]), 64'd5);
    check("single_dout1", 64'(dout[2*DW-1:DW]), 64'd5);
    check("single_level_zero", 64'(level), 64'd0);
    step();
    check("single_ack_pulse", 64'(ack_r), 64'd0);
    check("single_dout_hold", 64'(dout[DW-1:0]), 64'd5);

    // full: consumers idle, four words
    c_en = 2'b00;
    up_limit = up_sent + 4;
    next_val = 32'd0;
    n = 0;
    while (level !== 3'd4 && n < 60) begin step(); n++; end
    check("full_fill_timeout", 64'(n < 60), 64'd1);
    check("full_level", 64'(level), 64'd4);
    step();
    step();
    check("full_req_l_low", 64'(req_l), 64'd0);
    g0 = got0;
    lim0 = got0 + 4;
    c_en = 2'b01;
    n = 0;
    while (got0 != g0 + 4 && n < 60) begin step(); n++; end
    check("full_c0_read_timeout", 64'(n < 60), 64'd1);
    check("full_c0_level", 64'(level), 64'd4);
    check("full_c0_req_l", 64'(req_l), 64'd0);
    lim0 = got0 + 1000000;
    for (int k = 0; k < 4; k++) begin
      step();
      check("full_c0_empty_no_ack", 64'(ack_r[0]), 64'd0);
    end
    lim1 = got1 + 1;
    c_en = 2'b11;
    n = 0;
    while (ack_r[1] !== 1'b1 && n < 20) begin step(); n++; end
    check("full_c1_ack_timeout", 64'(n < 20), 64'd1);
    check("full_c1_level", 64'(level), 64'd3);
    check("full_c1_req_l_same_edge", 64'(req_l), 64'd0);
    step();
    check("full_c1_req_l_next_edge", 64'(req_l), 64'd1);

    // violation: refill, then stray ack_l with din=77 while req_l is low
    up_limit = up_sent + 1;
    next_val = 32'd100;
    n = 0;
    while (level !== 3'd4 && n < 20) begin step(); n++; end
    check("viol_fill_timeout", 64'(n < 20), 64'd1);
    check("viol_req_l_low", 64'(req_l), 64'd0);
    inj_pending = 1'b1;
    step();
    check("viol_ack_driven", 64'(ack_l), 64'd1);
    step();
    check("viol_level", 64'(level), 64'd4);
    check("viol_req_l", 64'(req_l), 64'd0);
    lim0 = got0 + 1000000;
    lim1 = got1 + 1000000;
    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 60) begin step(); n++; end
    check("viol_drain_timeout", 64'(n < 60), 64'd1);
    step();
    step();
    check("viol_drained_level", 64'(level), 64'd0);

    // concurrency: write plus both reads on one edge
    c_en = 2'b00;
    up_limit = up_sent + 2;
    next_val = 32'd200;
    n = 0;
    while (!(level === 3'd2 && req_l === 1'b1) && n < 30) begin step(); n++; end
    check("conc_setup_timeout", 64'(n < 30), 64'd1);
    up_limit = up_sent + 1;
    lim0 = got0 + 1;
    lim1 = got1 + 1;
    c_en = 2'b11;
    step();
    check("conc_ack_l_driven", 64'(ack_l), 64'd1);
    step();
    check("conc_ack_both", 64'(ack_r), 64'd3);
    check("conc_level", 64'(level), 64'd2);
    check("conc_dout0", 64'(dout[DW-1:0]), 64'd200);
    check("conc_dout1", 64'(dout[2*DW-1:DW]), 64'd200);
    lim0 = got0 + 1000000;
    lim1 = got1 + 1000000;
    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 60) begin step(); n++; end
    check("conc_drain_timeout", 64'(n < 60), 64'd1);
    step();
    step();
    check("conc_drained_level", 64'(level), 64'd0);

    // stream with consumer 1 randomly stalling; pointers wrap many times
    g0 = got0;
    g1 = got1;
    c_rand = 2'b10;
    up_limit = up_sent + 5000;
    next_val = 32'd0;
    n = 0;
    while ((got0 != g0 + 5000 || got1 != g1 + 5000) && n < 60000) begin step(); n++; end
    check("stream_timeout", 64'(n < 60000), 64'd1);
    check("stream_q0_empty", 64'(exp_q0.size()), 64'd0);
    check("stream_q1_empty", 64'(exp_q1.size()), 64'd0);
    step();
    step();
    check("stream_level", 64'(level), 64'd0);
    c_rand = 2'b00;

    // reset mid-stream with three entries occupied
    c_en = 2'b00;
    up_limit = up_sent + 10;
    next_val = 32'd300;
    n = 0;
    while (level !== 3'd3 && n < 40) begin step(); n++; end
    check("mid_fill_timeout", 64'(n < 40), 64'd1);
    rst = 1'b0;
    up_limit = up_sent;
    #1;
    check("mid_rst_req_l", 64'(req_l), 64'd0);
    check("mid_rst_ack_r", 64'(ack_r), 64'd0);
    check("mid_rst_dout", 64'(dout), 64'd0);
    check("mid_rst_level", 64'(level), 64'd0);
    step();
    step();
    check("mid_rst_hold_level", 64'(level), 64'd0);
    rst = 1'b1;
    up_limit = up_sent + 1;
    next_val = 32'd900;
    lim0 = got0 + 1;
    lim1 = got1 + 1;
    c_en = 2'b11;
    n = 0;
    while (ack_r === 2'b00 && n < 20) begin step(); n++; end
    check("post_rst_timeout", 64'(n < 20), 64'd1);
    check("post_rst_ack", 64'(ack_r), 64'd3);
    check("post_rst_dout0", 64'(dout[DW-1:0]), 64'd900);
    check("post_rst_dout1", 64'(dout[2*DW-1:DW]), 64'd900);
    step();
    step();
    check("post_rst_level", 64'(level), 64'd0);
    check("post_rst_q0_empty", 64'(exp_q0.size()), 64'd0);
    check("post_rst_q1_empty", 64'(exp_q1.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
